// File: rtl/wb_master_if_pkg.sv
// Shared Wishbone definitions: FSM state encoding, default bus widths, counter width helper.
package wb_master_if_pkg;

  localparam int WB_DW_DEF = 8;
  localparam int WB_AW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_master_if_if.sv
// Wishbone pipelined bus bundle; signal names are from the master's point of view.
interface wb_master_if_if
  import wb_master_if_pkg::*;
#(
  parameter int DW = WB_DW_DEF,
  parameter int AW = WB_AW_DEF
) ();

  logic          cyc_o;
  logic          lock_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic          stall_i;
  logic          ack_i;
  logic [DW-1:0] dat_i;

  modport master (
    output cyc_o, lock_o, stb_o, we_o, adr_o, dat_o,
    input  stall_i, ack_i, dat_i
  );

  modport slave (
    input  cyc_o, lock_o, stb_o, we_o, adr_o, dat_o,
    output stall_i, ack_i, dat_i
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; tc_o flags the last allowed cycle.
module wb_timeout_ctr
  import wb_master_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int W = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              cnt_q <= '0;
    else if (clr_i)         cnt_q <= '0;
    else if (en_i && !tc_o) cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/wb_master_if.sv
// Single-outstanding Wishbone pipelined initiator with a valid/ready client side.
// Define WB_MASTER_TIMEOUT_EN to abort unacknowledged cycles after TIMEOUT_CYCLES.
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DW_DEF,
  parameter int WB_ADDR_WIDTH  = WB_AW_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic                     req_lock_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_dat_i,
  output logic                     resp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] resp_dat_o,
  output logic                     resp_err_o,
  wb_master_if_if.master           wb
);

  wb_state_e                state_q;
  logic                     cyc_q, stb_q, we_q, lock_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [WB_DATA_WIDTH-1:0] dat_q;
  logic                     req_ready_q, resp_valid_q, resp_err_q;
  logic [WB_DATA_WIDTH-1:0] resp_dat_q;
  logic                     accept, to_tc;

  assign accept = req_valid_i & req_ready_q;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  ((state_q == ST_REQ) || (state_q == ST_WAIT)),
    .tc_o  (to_tc)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_tc = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_dat_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_REQ;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= req_we_i;
            lock_q      <= req_lock_i;
            adr_q       <= req_adr_i;
            dat_q       <= req_dat_i;
            req_ready_q <= 1'b0;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_REQ, ST_WAIT: begin
          // An ack in the terminal-count cycle still completes normally.
          if (wb.ack_i || to_tc) begin
            state_q      <= ST_RESP;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            lock_q       <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~wb.ack_i;
            resp_dat_q   <= wb.ack_i ? wb.dat_i : '0;
          end else if ((state_q == ST_REQ) && !wb.stall_i) begin
            state_q <= ST_WAIT;
            stb_q   <= 1'b0;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb.cyc_o     = cyc_q;
  assign wb.stb_o     = stb_q;
  assign wb.we_o      = we_q;
  assign wb.lock_o    = lock_q;
  assign wb.adr_o     = adr_q;
  assign wb.dat_o     = dat_q;
  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_dat_o   = resp_dat_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Bench for wb_master_if: RAM slave model with programmable stall/ack delay, response scoreboard.
module tb_wb_master_if;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_lock_i = 1'b0;
  logic [15:0] req_adr_i = '0;
  logic [7:0]  req_dat_i = '0;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic [7:0]  resp_dat_o;

  always #5 clk = ~clk;

  wb_master_if_if #(.DW(8), .AW(16)) wb ();

  wb_master_if #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_lock_i(req_lock_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .resp_valid_o(resp_valid_o), .resp_dat_o(resp_dat_o), .resp_err_o(resp_err_o),
    .wb(wb)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- slave model (driven on negedge) ----------------
  logic [7:0] mem [256];
  int  cfg_stall = 0, cfg_dly = 1;
  bit  cfg_noack = 0, spur = 0;
  int  st_left = 0, wt_left = 0;
  bit  s_busy = 0, s_new = 0;

  task automatic slave_ack();
    wb.ack_i = 1'b1;
    if (wb.we_o) begin
      mem[wb.adr_o[7:0]] = wb.dat_o;
      wb.dat_i = ~wb.dat_o;
    end else begin
      wb.dat_i = mem[wb.adr_o[7:0]];
    end
  endtask

  always @(negedge clk) begin
    wb.ack_i   = 1'b0;
    wb.stall_i = 1'b0;
    wb.dat_i   = 8'hEE;
    if (!wb.cyc_o) begin
      s_busy = 0;
      s_new  = 0;
      if (spur) begin
        wb.ack_i   = 1'b1;
        wb.stall_i = 1'b1;
        wb.dat_i   = 8'h99;
      end
    end else if (wb.stb_o && !s_busy) begin
      if (!s_new) begin
        s_new   = 1;
        st_left = cfg_stall;
      end
      if (st_left > 0) begin
        wb.stall_i = 1'b1;
        st_left--;
      end else if (cfg_noack) begin
        s_busy = 1;
      end else if (cfg_dly == 0) begin
        slave_ack();
      end else begin
        s_busy  = 1;
        wt_left = cfg_dly;
      end
    end else if (s_busy && !cfg_noack) begin
      wt_left--;
      if (wt_left == 0) slave_ack();
    end
  end

  // ---------------- scoreboard / bus monitor ----------------
  typedef struct {
    logic [7:0] dat;
    bit         err;
    int         acc;
    int         lat;
    int         stbn;
  } sb_t;

  sb_t         sb[$];
  sb_t         e;
  logic [15:0] cur_adr = '0;
  logic [7:0]  cur_dat = '0;
  bit          cur_we = 0, cur_lock = 0;
  int          stb_n = 0, resp_cnt = 0;
  bit          bus_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      stb_n   = 0;
      bus_bad = 0;
    end else begin
      if (wb.cyc_o) begin
        if (wb.stb_o) stb_n++;
        if (wb.adr_o !== cur_adr || wb.we_o !== cur_we || wb.lock_o !== cur_lock ||
            req_ready_o !== 1'b0 || (cur_we && wb.dat_o !== cur_dat))
          bus_bad = 1;
      end
      if (sb.size() == 0) begin
        chk("no_spurious_resp", 32'(resp_valid_o), 0);
      end else if (resp_valid_o) begin
        e = sb.pop_front();
        chk("resp_dat", 32'(resp_dat_o), 32'(e.dat));
        chk("resp_err", 32'(resp_err_o), 32'(e.err));
        chk("resp_latency", 32'(cyc_cnt - e.acc), 32'(e.lat));
        chk("stb_cycles", 32'(stb_n), 32'(e.stbn));
        chk("bus_held_stable", 32'(bus_bad), 0);
        chk("cyc_stb_low_in_resp", 32'({wb.cyc_o, wb.stb_o}), 0);
        stb_n   = 0;
        bus_bad = 0;
        resp_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit we, input bit lk, input logic [15:0] adr, input logic [7:0] dat,
                       input int s, input int d, input bit na,
                       input logic [7:0] edat, input bit eerr, input int elat);
    int  k = 0;
    sb_t x;
    @(negedge clk);
    while (!req_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_before_issue", 32'(req_ready_o), 1);
    cfg_stall = s; cfg_dly = d; cfg_noack = na;
    cur_adr = adr; cur_dat = dat; cur_we = we; cur_lock = lk;
    req_valid_i = 1'b1; req_we_i = we; req_lock_i = lk; req_adr_i = adr; req_dat_i = dat;
    @(posedge clk);
    #1;
    x.dat = edat; x.err = eerr; x.acc = cyc_cnt; x.lat = elat; x.stbn = s + 1;
    sb.push_back(x);
    // Scramble request inputs: the DUT must have latched them on acceptance.
    req_valid_i = 1'b0;
    req_we_i    = ~we;
    req_lock_i  = ~lk;
    req_adr_i   = 16'($urandom);
    req_dat_i   = 8'($urandom);
  endtask

  task automatic wait_resp(input string name);
    int start = resp_cnt;
    int k = 0;
    while (resp_cnt == start && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk(name, 32'(resp_cnt != start), 1);
    #1;
    if (resp_cnt != start) chk("req_ready_after_resp", 32'(req_ready_o), 1);
  endtask

  typedef struct {
    bit          we;
    bit          lk;
    logic [15:0] adr;
    logic [7:0]  dat;
    int          s;
    int          d;
    logic [7:0]  edat;
    int          lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 16'h1234, 8'hA5, 0, 1, 8'h5A, 2};  // write, ack 1 cycle after stb
    vt[1] = '{1'b0, 1'b0, 16'h0010, 8'h00, 3, 0, 8'h3C, 4};  // read, 3 stalls then ack
    vt[2] = '{1'b1, 1'b0, 16'h0001, 8'h55, 0, 1, 8'hAA, 2};  // back-to-back write...
    vt[3] = '{1'b0, 1'b0, 16'h0001, 8'h00, 0, 1, 8'h55, 2};  // ...then read back
    vt[4] = '{1'b1, 1'b1, 16'h00FF, 8'h0F, 1, 2, 8'hF0, 4};  // locked write
    vt[5] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 0, 0, 8'h0F, 1};  // same-cycle accept+ack
    vt[6] = '{1'b0, 1'b1, 16'h1234, 8'h00, 2, 3, 8'hA5, 6};  // locked read, long wait
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb_we_lock", 32'({wb.cyc_o, wb.stb_o, wb.we_o, wb.lock_o}), 0);
    chk("rst_adr", 32'(wb.adr_o), 0);
    chk("rst_dat", 32'(wb.dat_o), 0);
    chk("rst_resp", 32'({resp_valid_o, resp_err_o, resp_dat_o}), 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_rst", 32'(req_ready_o), 1);

    // table-driven transactions
    for (int i = 0; i < 7; i++) begin
      issue(vt[i].we, vt[i].lk, vt[i].adr, vt[i].dat, vt[i].s, vt[i].d, 1'b0,
            vt[i].edat, 1'b0, vt[i].lat);
      wait_resp($sformatf("resp_arrived_v%0d", i));
      if (i == 0) chk("slave_mem_1234", 32'(mem[8'h34]), 32'h0000_00A5);
    end

    // spurious ack/stall while idle
    @(negedge clk);
    spur = 1;
    repeat (4) @(negedge clk);
    spur = 0;
    @(posedge clk);
    #1;
    chk("idle_after_spurious", 32'({wb.cyc_o, req_ready_o}), 32'h1);
    chk("resp_dat_hold", 32'(resp_dat_o), 32'(vt[6].edat));

`ifdef WB_MASTER_TIMEOUT_EN
    // unmapped address: abort after 8 cycles, then a normal read
    issue(1'b0, 1'b0, 16'h0200, 8'h00, 0, 0, 1'b1, 8'h00, 1'b1, 8);
    wait_resp("resp_arrived_timeout");
    issue(1'b0, 1'b0, 16'h0001, 8'h00, 0, 1, 1'b0, 8'h55, 1'b0, 2);
    wait_resp("resp_arrived_after_timeout");
`endif

    // reset pulsed while waiting for ack
    issue(1'b0, 1'b0, 16'h0003, 8'h00, 0, 0, 1'b1, 8'h00, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_wait", 32'({wb.cyc_o, wb.stb_o}), 32'h2);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_async_cyc_stb", 32'({wb.cyc_o, wb.stb_o}), 0);
    chk("rst_async_ready", 32'(req_ready_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_midrst", 32'(req_ready_o), 1);
    repeat (5) @(negedge clk);
    issue(1'b0, 1'b0, 16'h0001, 8'h00, 0, 1, 1'b0, 8'h55, 1'b0, 2);
    wait_resp("resp_arrived_after_midrst");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
